// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_pkg
//  Description : Shared types and constants for the BNN MAC sequencer slice:
//                window geometry, row/window/popcount types and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    // Window rows and row width (one binary row per weight/image beat)
    localparam int BNN_N = 7;
    // Width of the signed accumulated popcount returned by the engine
    localparam int POP_W = 7;

    typedef logic [BNN_N-1:0]             row_t;
    typedef logic [BNN_N-1:0][BNN_N-1:0]  window_t;
    typedef logic signed [POP_W-1:0]      popcnt_t;
    typedef logic [2:0]                   row_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_LOAD_W   = 3'd2,
        ST_LOAD_IMG = 3'd3,
        ST_ACCUM    = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_OUT      = 3'd6
    } state_e;

    // Binarize a signed popcount against a signed threshold.
    function automatic logic thresh_bit(input popcnt_t pop, input int thresh);
        return (int'(pop) >= thresh);
    endfunction

endpackage : bnn_pkg
`default_nettype wire

// File: rtl/bnn_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_row_buffer
//  Description : 7x7 image window register. One row is written per accepted
//                beat at an arbitrary row index; the whole window is cleared
//                synchronously and otherwise holds its contents.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                clr          - synchronous clear of the whole window
//                wr_en        - write wr_row into row wr_idx
//                wr_idx       - destination row index (0..6)
//                wr_row       - row data
//                window       - registered 7x7 window
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_row_buffer
    import bnn_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     wr_en,
    input  row_cnt_t wr_idx,
    input  row_t     wr_row,
    output window_t  window
);

    window_t r_win;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_win <= '0;
        end else if (wr_en) begin
            r_win[wr_idx] <= wr_row;
        end
    end

    assign window = r_win;

endmodule : bnn_row_buffer
`default_nettype wire

// File: rtl/bnn_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_mac_sequencer
//  Description : Sequences one 7x7 binary window through an external
//                XNOR-popcount engine: clear engine, stream 7 weight rows,
//                stream 7 image rows into the window register, strobe 7
//                accumulate steps, capture and binarize the popcount, then
//                hold the result until accepted.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                en                       - allow a new window from IDLE
//                w_valid/w_ready/w_data   - weight-row stream
//                img_valid/img_ready/img_row - image-row stream
//                eng_rst, eng_w_en, eng_w_input, eng_c_rst, eng_img
//                                         - engine control / data
//                eng_popcnt               - engine accumulated popcount
//                res_valid/res_ready      - result handshake
//                res_sum, res_bit, res_idx - captured result and window index
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_mac_sequencer
    import bnn_pkg::*;
#(
    parameter int THRESH = 21,
    parameter int N      = 7
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        w_valid,
    output logic        w_ready,
    input  row_t        w_data,
    input  logic        img_valid,
    output logic        img_ready,
    input  row_t        img_row,
    output logic        eng_rst,
    output logic        eng_w_en,
    output row_t        eng_w_input,
    output logic        eng_c_rst,
    output window_t     eng_img,
    input  popcnt_t     eng_popcnt,
    output logic        res_valid,
    input  logic        res_ready,
    output popcnt_t     res_sum,
    output logic        res_bit,
    output logic [15:0] res_idx
);

    localparam row_cnt_t LAST_ROW = row_cnt_t'(N - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    row_cnt_t    r_row_cnt;
    logic        r_rst_q;
    popcnt_t     r_res_sum;
    logic        r_res_bit;
    logic [15:0] r_res_idx;

    logic        w_clear;
    logic        w_advance;
    logic        w_last;
    logic        w_img_fire;
    logic        w_res_fire;
    logic        w_capture;
    row_cnt_t    w_img_idx;

    assign w_last = (r_row_cnt == LAST_ROW);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        img_ready   = 1'b0;
        eng_w_en    = 1'b0;
        eng_c_rst   = 1'b0;
        res_valid   = 1'b0;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_img_fire  = 1'b0;
        w_res_fire  = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    eng_w_en  = 1'b1;
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_LOAD_IMG;
                    end
                end
            end
            ST_LOAD_IMG: begin
                img_ready = 1'b1;
                if (img_valid) begin
                    w_img_fire = 1'b1;
                    w_advance  = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                eng_c_rst = 1'b1;
                w_advance = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_res_fire  = 1'b1;
                    w_state_nxt = en ? ST_CLEAR : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared row/step counter: counts accepted weight rows, accepted image
    // rows and accumulate steps; wraps to 0 on the 7th event of each phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_row_cnt <= '0;
        end else if (w_advance) begin
            r_row_cnt <= w_last ? row_cnt_t'(0) : r_row_cnt + 3'd1;
        end
    end

    // Engine reset is stretched one cycle past rst so the engine sees it on
    // the edge that puts the sequencer into IDLE even for a 1-cycle pulse.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    assign eng_rst     = rst | r_rst_q | w_clear;
    assign eng_w_input = w_data;

    // ------------------------------------------------------------------
    // Image window: row k lands at index 6-k so image row 0 lines up with
    // the first weight row the engine consumes.
    // ------------------------------------------------------------------
    assign w_img_idx = LAST_ROW - r_row_cnt;

    bnn_row_buffer u_row_buffer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clear),
        .wr_en  (w_img_fire),
        .wr_idx (w_img_idx),
        .wr_row (img_row),
        .window (eng_img)
    );

    // ------------------------------------------------------------------
    // Result capture and window index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_sum <= '0;
            r_res_bit <= 1'b0;
        end else if (w_capture) begin
            r_res_sum <= eng_popcnt;
            r_res_bit <= thresh_bit(eng_popcnt, THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_idx <= '0;
        end else if (w_res_fire) begin
            r_res_idx <= r_res_idx + 16'd1;
        end
    end

    assign res_sum = r_res_sum;
    assign res_bit = r_res_bit;
    assign res_idx = r_res_idx;

endmodule : bnn_mac_sequencer
`default_nettype wire
